// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer driving the mini-CPU 8-bit ALU: fetches 16-bit instructions,
// reads a small register file, sequences ALU operations and emits register values.
module alu_sequencer #(
  parameter int unsigned NREGS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr_data,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_op,
  input  logic [7:0]  alu_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_data,
  output logic        flag_z,
  output logic        err
);

  localparam int unsigned DW  = 8;
  localparam int unsigned IW  = 16;
  localparam int unsigned OPW = 4;
  localparam int unsigned RIW = 2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_OUT    = 3'd5;

  localparam logic [OPW-1:0] OP_ADD  = 4'h0;
  localparam logic [OPW-1:0] OP_SUB  = 4'h1;
  localparam logic [OPW-1:0] OP_AND  = 4'h2;
  localparam logic [OPW-1:0] OP_OR   = 4'h3;
  localparam logic [OPW-1:0] OP_LDI  = 4'h4;
  localparam logic [OPW-1:0] OP_ADDI = 4'h5;
  localparam logic [OPW-1:0] OP_OUT  = 4'h6;

  logic [2:0]    state_q, state_nx;
  logic          run_q;
  logic [IW-1:0] instr_q, instr_nx;
  logic [DW-1:0] result_q, result_nx;
  logic [DW-1:0] regs_q [NREGS];

  logic [DW-1:0]  alu_a_nx, alu_b_nx, res_data_nx;
  logic [OPW-1:0] alu_op_nx;
  logic           instr_ready_nx, res_valid_nx, flag_z_nx, err_nx;
  logic           wr_en;
  logic [DW-1:0]  wr_data;

  logic [OPW-1:0] opcode;
  logic [RIW-1:0] rd, rs;
  logic [DW-1:0]  imm;

  assign opcode = instr_q[15:12];
  assign rd     = instr_q[11:10];
  assign rs     = instr_q[9:8];
  assign imm    = instr_q[7:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  // Next-state, datapath next values and registered-output next values
  always_comb begin
    state_nx    = state_q;
    instr_nx    = instr_q;
    result_nx   = result_q;
    alu_a_nx    = '0;
    alu_b_nx    = '0;
    alu_op_nx   = '0;
    res_data_nx = res_data;
    flag_z_nx   = flag_z;
    err_nx      = err;
    wr_en       = 1'b0;
    wr_data     = result_q;

    case (state_q)
      // IDLE lingers one settle cycle after reset release before fetching
      S_IDLE: begin
        if (run_q) state_nx = S_FETCH;
      end
      S_FETCH: begin
        if (instr_valid && instr_ready) begin
          instr_nx = instr_data;
          state_nx = S_DECODE;
        end
      end
      // Operands are latched straight into the ALU drive registers for EXEC
      S_DECODE: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            alu_a_nx  = regs_q[rd];
            alu_b_nx  = regs_q[rs];
            alu_op_nx = {2'b00, opcode[1:0]};
            state_nx  = S_EXEC;
          end
          OP_ADDI: begin
            alu_a_nx  = regs_q[rd];
            alu_b_nx  = imm;
            alu_op_nx = OP_ADD;
            state_nx  = S_EXEC;
          end
          OP_LDI: begin
            state_nx = S_WB;
          end
          OP_OUT: begin
            res_data_nx = regs_q[rd];
            state_nx    = S_OUT;
          end
          default: begin
            err_nx   = 1'b1;
            state_nx = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        result_nx = alu_out;
        flag_z_nx = (alu_out == '0);
        state_nx  = S_WB;
      end
      S_WB: begin
        wr_en    = 1'b1;
        wr_data  = (opcode == OP_LDI) ? imm : result_q;
        state_nx = S_FETCH;
      end
      S_OUT: begin
        if (res_valid && res_ready) state_nx = S_FETCH;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    instr_ready_nx = (state_nx == S_FETCH);
    res_valid_nx   = (state_nx == S_OUT);
  end

  // Datapath, register file and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      instr_q     <= '0;
      result_q    <= '0;
      regs_q      <= '{default: '0};
      instr_ready <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      flag_z      <= 1'b0;
      err         <= 1'b0;
    end else begin
      run_q       <= 1'b1;
      instr_q     <= instr_nx;
      result_q    <= result_nx;
      instr_ready <= instr_ready_nx;
      res_valid   <= res_valid_nx;
      res_data    <= res_data_nx;
      alu_a       <= alu_a_nx;
      alu_b       <= alu_b_nx;
      alu_op      <= alu_op_nx;
      flag_z      <= flag_z_nx;
      err         <= err_nx;
      if (wr_en) regs_q[rd] <= wr_data;
    end
  end

endmodule
